// File: rtl/ruban_pkg.sv
// Shared definitions for the ruban mux/demux pair: default frame geometry
// and the capture-side state encoding.
package ruban_pkg;

    localparam int RUBAN_WIDTH = 16;
    localparam int RUBAN_SEL_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_HOLD    = 2'd2
    } ruban_state_e;

endpackage : ruban_pkg

// File: rtl/ruban_sel_counter.sv
// Position counter for the demux select: synchronous clear, count enable,
// wraps to zero after LAST and flags the terminal count combinationally.
module ruban_sel_counter #(
    parameter int SEL_W = 4,
    parameter int LAST  = (1 << SEL_W) - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [SEL_W-1:0] cnt,
    output logic             tc
);

    localparam logic [SEL_W-1:0] LAST_CNT = SEL_W'(LAST);

    assign tc = (cnt == LAST_CNT);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule : ruban_sel_counter

// File: rtl/ruban_demux_capture.sv
// Serial-to-parallel frame capture: routes each accepted bit to position sel
// of a shadow register and presents the completed frame on out_word.
module ruban_demux_capture
    import ruban_pkg::*;
#(
    parameter int WIDTH = RUBAN_WIDTH,
    parameter int SEL_W = RUBAN_SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] out_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    ruban_state_e     state_q;
    ruban_state_e     state_d;
    logic [WIDTH-1:0] shadow_q;
    logic [WIDTH-1:0] shadow_wr;
    logic             xfer;
    logic             sel_tc;
    logic             frame_done;
    logic             clr_frame;

    assign in_ready   = (state_q == ST_CAPTURE);
    assign out_valid  = (state_q == ST_HOLD);
    assign busy       = (state_q != ST_IDLE);

    // Abort wins over a transfer in the same cycle, so it also masks the write.
    assign xfer       = in_ready && in_valid && !abort;
    assign frame_done = xfer && sel_tc;

    ruban_sel_counter #(
        .SEL_W (SEL_W),
        .LAST  (WIDTH - 1)
    ) u_sel_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_frame),
        .en    (xfer),
        .cnt   (sel),
        .tc    (sel_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can infer a latch.
    always_comb begin
        state_d   = state_q;
        clr_frame = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_CAPTURE;
                    clr_frame = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (frame_done) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    if (start) begin
                        state_d   = ST_CAPTURE;
                        clr_frame = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (abort) begin
            state_d   = ST_IDLE;
            clr_frame = 1'b1;
        end
    end

    // Shadow with the incoming bit merged in; also the completed frame on the
    // last transfer, so out_word loads in the same edge as the final write.
    always_comb begin
        shadow_wr      = shadow_q;
        shadow_wr[sel] = in_bit;
    end

    // NOTE: shadow and out_word are plain flops, not a memory, so they take
    // the asynchronous reset like the rest of the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
        end else if (clr_frame) begin
            shadow_q <= '0;
        end else if (xfer) begin
            shadow_q <= shadow_wr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_word <= '0;
        end else if (frame_done) begin
            out_word <= shadow_wr;
        end
    end

endmodule : ruban_demux_capture

// File: doc/ruban_demux_capture.md
RUBAN_DEMUX_CAPTURE -- requirements
Module: ruban_demux_capture

Interface
REQ-001 Parameter WIDTH, default 16, number of demultiplexed output bit positions per frame.
REQ-002 Parameter SEL_W, default 4, select/index width; SHALL equal clog2(WIDTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  one-cycle request to begin a new frame capture.
REQ-006 abort  input  1  discards the current frame and returns to idle.
REQ-007 in_bit  input  1  serial data bit to be routed to output position sel.
REQ-008 in_valid  input  1  in_bit valid this cycle.
REQ-009 in_ready  output  1  block accepts in_bit this cycle.
REQ-010 sel  output  SEL_W  index of the position the next accepted bit is written to.
REQ-011 out_word  output  WIDTH  completed frame; bit i holds the i-th accepted bit.
REQ-012 out_valid  output  1  out_word holds a complete frame.
REQ-013 out_ready  input  1  downstream consumes out_word when out_valid is high.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 FSM states: IDLE, CAPTURE, HOLD; encoding internal.
REQ-016 IDLE: in_ready=0, out_valid=0; start=1 -> CAPTURE, sel cleared to 0, shadow register cleared to 0.
REQ-017 CAPTURE: in_ready=1; a transfer occurs when in_valid and in_ready are both high.
REQ-018 On transfer: shadow[sel] <= in_bit; all other shadow bits unchanged; sel <= sel+1.
REQ-019 Transfer with sel=WIDTH-1: shadow bit written, out_word <= completed shadow in the same edge, sel wraps to 0, state -> HOLD.
REQ-020 First out_valid occurs the cycle after the WIDTH-th transfer (latency 1 cycle).
REQ-021 in_valid low in CAPTURE: no state change; gaps of any length are permitted.
REQ-022 HOLD: out_valid=1, in_ready=0; out_word stable until the handshake completes.
REQ-023 HOLD with out_ready=1: out_valid drops next cycle; state -> IDLE, or -> CAPTURE with sel=0 if start=1 in the same cycle.
REQ-024 start is ignored in CAPTURE and in HOLD without out_ready.
REQ-025 abort=1 in any state: next state IDLE, sel=0, out_valid=0, shadow cleared; abort takes priority over start, transfer and handshake in the same cycle.
REQ-026 out_word retains the last completed frame in IDLE and CAPTURE; only a new completed frame or reset changes it.
REQ-027 busy = (state != IDLE), combinational from state.

Reset
REQ-028 rst_n low asynchronously forces: state IDLE, sel 0, shadow 0, out_word 0, out_valid 0, in_ready 0, busy 0.
REQ-029 Reset asserted mid-CAPTURE or mid-HOLD discards the partial/pending frame; no out_valid pulse after release until a new full frame.
REQ-030 Reset release is synchronized by the system; block only samples inputs on the first edge after rst_n is high.

Structure
REQ-031 State encoding constants and default WIDTH/SEL_W SHALL live in a shared package (ruban_pkg) shared with the mux side.
REQ-032 One sub-module, ruban_sel_counter (SEL_W-bit counter with clear, enable, terminal-count flag), SHALL be instantiated for sel.
REQ-033 Target size 120-400 RTL lines; no latches, no combinational loops, no sensitivity lists other than clock/reset edges for sequential logic.

Verification
REQ-034 Reset, start, 16 transfers of bits 1,0,1,1,0,0,0,0,1,1,1,1,0,1,0,1 -> out_word=16'hAF0D, out_valid high one cycle after the 16th transfer.
REQ-035 Same frame with in_valid toggled every other cycle -> identical out_word 16'hAF0D, sel steps 0..15 only on transfers.
REQ-036 HOLD with out_ready=0 for 10 cycles, then 1 with start=1 -> out_word stable 10 cycles, out_valid drops, CAPTURE entered with sel=0.
REQ-037 abort after 7 transfers -> IDLE, sel=0, out_valid never asserted, out_word keeps previous value.
REQ-038 rst_n pulsed low mid-CAPTURE (sel=9) -> all outputs 0 immediately (async), no out_valid after release.
REQ-039 Simultaneous abort and 16th transfer -> IDLE, out_valid stays 0, out_word unchanged.
